// File: rtl/mul_seq_ctrl_if.sv
// Handshake and strobe bundle between the multiplier controller and the
// host/datapath. The controller uses the slave view; the host and the
// datapath together form the master view.
interface mul_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             done_ack;
  logic             abort;
  logic             eqz;
  logic             ldA;
  logic             ldB;
  logic             clrP;
  logic             ldP;
  logic             decB;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, done_ack, abort, eqz,
    input  ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, done_ack, abort, eqz,
    output ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Moore controller for the repeated-addition multiplier. Loads A, then B
// (clearing P), then alternates CHECK/ADD until B reaches zero or the
// iteration limit trips. All outputs come straight from registers.
module mul_seq_ctrl #(
  parameter int               CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CHECK,
    S_ADD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] iter_reg;
  // {ldA, ldB, clrP, ldP, decB, busy, done, err}
  logic [7:0]       out_reg;

  // Output pattern for each state; registered alongside the state so the
  // outputs are exactly a decode of the state register.
  function automatic logic [7:0] decode(input state_t s);
    case (s)
      S_LOAD_A: decode = 8'b1000_0100;
      S_LOAD_B: decode = 8'b0110_0100;
      S_CHECK:  decode = 8'b0000_0100;
      S_ADD:    decode = 8'b0001_1100;
      S_DONE:   decode = 8'b0000_0010;
      S_ERR:    decode = 8'b0000_0011;
      default:  decode = 8'b0000_0000;
    endcase
  endfunction

  // Next-state logic: abort wins everywhere outside IDLE.
  always_comb begin
    state_next = state_reg;
    if (bus.abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:   if (bus.start && !bus.abort) state_next = S_LOAD_A;
        S_LOAD_A: state_next = S_LOAD_B;
        S_LOAD_B: state_next = S_CHECK;
        S_CHECK: begin
          if (bus.eqz)                  state_next = S_DONE;
          else if (iter_reg == MAX_ITER) state_next = S_ERR;
          else                          state_next = S_ADD;
        end
        S_ADD:    state_next = S_CHECK;
        S_DONE, S_ERR: begin
          // A new start doubles as the acknowledge for the previous result.
          if (bus.start)         state_next = S_LOAD_A;
          else if (bus.done_ack) state_next = S_IDLE;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // State, registered outputs and iteration counter. The counter update
  // depends only on the current state, so an ADD cycle is counted even if
  // an abort lands in it (the datapath did perform that add).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      out_reg   <= 8'b0;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= decode(state_next);
      case (state_reg)
        S_LOAD_A: iter_reg <= '0;
        S_ADD:    if (iter_reg != CNT_SAT) iter_reg <= iter_reg + CNT_ONE;
        default:  iter_reg <= iter_reg;
      endcase
    end
  end

  assign bus.ldA      = out_reg[7];
  assign bus.ldB      = out_reg[6];
  assign bus.clrP     = out_reg[5];
  assign bus.ldP      = out_reg[4];
  assign bus.decB     = out_reg[3];
  assign bus.busy     = out_reg[2];
  assign bus.done     = out_reg[1];
  assign bus.err      = out_reg[0];
  assign bus.iter_cnt = iter_reg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl. Channel 0 uses the default iteration
// limit, channel 1 a limit of 4. Each channel has a small behavioural
// A/B/P datapath so eqz and the product follow the strobes.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  start    = 2'b00;
  logic [1:0]  done_ack = 2'b00;
  logic [1:0]  abort    = 2'b00;
  logic [15:0] din   [2];
  logic [7:0]  vec   [2];   // {ldA, ldB, clrP, ldP, decB, busy, done, err}
  logic [15:0] iter  [2];
  logic [15:0] p_val [2];

  int total = 0;
  int bad   = 0;

  localparam int V_IDLE = 'h00;
  localparam int V_LA   = 'h84;
  localparam int V_LB   = 'h64;
  localparam int V_CK   = 'h04;
  localparam int V_AD   = 'h1C;
  localparam int V_DN   = 'h02;
  localparam int V_ER   = 'h03;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    mul_seq_ctrl_if #(.CNT_W(16)) bus ();
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] p_q;

    assign bus.start    = start[gi];
    assign bus.done_ack = done_ack[gi];
    assign bus.abort    = abort[gi];
    assign bus.eqz      = (b_q == 16'd0);

    mul_seq_ctrl #(
      .CNT_W   (16),
      .MAX_ITER(gi == 0 ? 16'hFFFF : 16'd4)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign vec[gi]   = {bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB,
                        bus.busy, bus.done, bus.err};
    assign iter[gi]  = bus.iter_cnt;
    assign p_val[gi] = p_q;

    // Datapath model: operand loads, product accumulate, B countdown.
    always_ff @(posedge clk) begin
      if (bus.ldA) a_q <= din[gi];
      if (bus.ldB) b_q <= din[gi];
      else if (bus.decB) b_q <= b_q - 16'd1;
      if (bus.clrP) p_q <= 16'd0;
      else if (bus.ldP) p_q <= p_q + a_q;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start, feed A in LOAD_A and B in LOAD_B; returns in LOAD_B.
  task automatic launch(input int ch, input logic [15:0] a, input logic [15:0] b,
                        input string tag);
    start[ch] = 1'b1;
    tick();
    start[ch] = 1'b0;
    din[ch] = a;
    chk({tag, ".lda"}, 32'(vec[ch]), V_LA);
    tick();
    din[ch] = b;
    chk({tag, ".ldb"}, 32'(vec[ch]), V_LB);
  endtask

  // Bounded wait for done; counts cycles and ldP strobes seen on the way.
  task automatic wait_done(input int ch, input int budget, output int cyc, output int nadd);
    cyc = 0;
    nadd = 0;
    while (!vec[ch][1] && cyc < budget) begin
      tick();
      cyc++;
      if (vec[ch][4]) nadd++;
    end
    if (!vec[ch][1]) chk("timeout", 0, 1);
  endtask

  task automatic ack(input int ch, input string tag);
    done_ack[ch] = 1'b1;
    tick();
    done_ack[ch] = 1'b0;
    chk(tag, 32'(vec[ch]), V_IDLE);
  endtask

  // Strobe exclusivity rules, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 2; c++) begin
        chk("strobe_rules",
            int'(($countones({vec[c][7], vec[c][6], vec[c][4]}) <= 1) &&
                 (!vec[c][5] || vec[c][6]) &&
                 (!vec[c][3] || vec[c][4]) &&
                 !(vec[c][2] && vec[c][1])), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nadd;
    int exp_v;
    din[0] = 16'd0;
    din[1] = 16'd0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst.vec0", 32'(vec[0]), V_IDLE);
    chk("rst.vec1", 32'(vec[1]), V_IDLE);
    chk("rst.iter", 32'(iter[0]), 0);
    rst_n = 1'b1;
    tick();

    // 7 x 5, cycle-exact strobe sequence
    start[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) begin start[0] = 1'b0; din[0] = 16'd7; end
      if (k == 2) din[0] = 16'd5;
      exp_v = (k == 1) ? V_LA : (k == 2) ? V_LB : (k == 14) ? V_DN :
              (k % 2 == 1) ? V_CK : V_AD;
      chk($sformatf("t1.k%0d", k), 32'(vec[0]), exp_v);
    end
    chk("t1.iter", 32'(iter[0]), 5);
    chk("t1.p", 32'(p_val[0]), 35);
    repeat (3) tick();
    chk("t1.hold", 32'(vec[0]), V_DN);
    ack(0, "t1.ack");
    chk("t1.iter_kept", 32'(iter[0]), 5);

    // 9 x 0: straight to DONE
    launch(0, 16'd9, 16'd0, "t2");
    tick();
    chk("t2.check", 32'(vec[0]), V_CK);
    tick();
    chk("t2.done", 32'(vec[0]), V_DN);
    chk("t2.iter", 32'(iter[0]), 0);
    chk("t2.p", 32'(p_val[0]), 0);
    ack(0, "t2.ack");

    // Iteration limit 4 with B=6 -> ERR
    launch(1, 16'd3, 16'd6, "t3");
    wait_done(1, 40, cyc, nadd);
    chk("t3.vec", 32'(vec[1]), V_ER);
    chk("t3.cyc", cyc, 10);
    chk("t3.nadd", nadd, 4);
    chk("t3.iter", 32'(iter[1]), 4);
    chk("t3.p", 32'(p_val[1]), 12);
    ack(1, "t3.ack");

    // Abort during the second ADD
    launch(0, 16'd3, 16'd4, "t4");
    repeat (4) tick();
    chk("t4.add2", 32'(vec[0]), V_AD);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("t4.idle", 32'(vec[0]), V_IDLE);
    chk("t4.iter", 32'(iter[0]), 2);
    repeat (3) tick();
    chk("t4.nodone", 32'(vec[0]), V_IDLE);
    launch(0, 16'd3, 16'd4, "t4b");
    wait_done(0, 40, cyc, nadd);
    chk("t4b.cyc", cyc, 10);
    chk("t4b.p", 32'(p_val[0]), 12);
    chk("t4b.iter", 32'(iter[0]), 4);
    ack(0, "t4b.ack");

    // Asynchronous reset mid-CHECK, then 2 x 3
    launch(0, 16'd2, 16'd3, "t5");
    repeat (3) tick();
    chk("t5.check", 32'(vec[0]), V_CK);
    rst_n = 1'b0;
    #1;
    chk("t5.async", 32'(vec[0]), V_IDLE);
    chk("t5.async_iter", 32'(iter[0]), 0);
    tick();
    rst_n = 1'b1;
    chk("t5.released", 32'(vec[0]), V_IDLE);
    launch(0, 16'd2, 16'd3, "t5b");
    wait_done(0, 40, cyc, nadd);
    chk("t5b.cyc", cyc, 8);
    chk("t5b.p", 32'(p_val[0]), 6);
    chk("t5b.iter", 32'(iter[0]), 3);

    // Back-to-back start from DONE: 4 x 2
    launch(0, 16'd4, 16'd2, "t6");
    wait_done(0, 40, cyc, nadd);
    chk("t6.cyc", cyc, 6);
    chk("t6.p", 32'(p_val[0]), 8);
    chk("t6.iter", 32'(iter[0]), 2);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("t6.abort_done", 32'(vec[0]), V_IDLE);

    // start together with abort in IDLE stays IDLE
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    chk("t7.idle1", 32'(vec[0]), V_IDLE);
    tick();
    chk("t7.idle2", 32'(vec[0]), V_IDLE);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("t7.iter", 32'(iter[0]), 2);

    // start while busy is ignored and not queued: 5 x 1
    launch(0, 16'd5, 16'd1, "t8");
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("t8.check", 32'(vec[0]), V_CK);
    tick();
    chk("t8.add", 32'(vec[0]), V_AD);
    tick();
    chk("t8.check2", 32'(vec[0]), V_CK);
    tick();
    chk("t8.done", 32'(vec[0]), V_DN);
    chk("t8.p", 32'(p_val[0]), 5);
    chk("t8.iter", 32'(iter[0]), 1);
    tick();
    chk("t8.noqueue", 32'(vec[0]), V_DN);
    ack(0, "t8.ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
